counter_sequencer: RTL

- Synchronous run/stop controller and count register for the 4-bit LED counter on the DE1 board.
- Divides the board clock into a count-enable tick and sequences start/stop/clear commands from the push-buttons.
- Drives the count in the selected direction, with either wrap or saturate at the limits.
- Replaces free-running clocking of the counter with one clock domain and a qualified enable.

---
 rtl/counter_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer
//  Brief    : Run/stop/clear sequencer and prescaled 4-bit up/down counter.
//  Revision : 1.0
// ============================================================================
module counter_sequencer #(
   parameter int PRESCALE = 50000000,
   parameter int PS_W     = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       dir_up,
   input  logic       mode_wrap,
   output logic [3:0] count,
   output logic       tick,
   output logic       tc,
   output logic       running
);

   localparam logic [1:0]      c_ST_IDLE   = 2'd0;
   localparam logic [1:0]      c_ST_RUN    = 2'd1;
   localparam logic [1:0]      c_ST_PAUSED = 2'd2;
   localparam logic [1:0]      c_ST_DONE   = 2'd3;
   localparam logic [PS_W-1:0] c_PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] c_PS_ONE    = PS_W'(1);

   // Command vectors are ordered {clear, stop, start}; levels are {mode_wrap, dir_up}.
   logic [2:0]      cmd_s1_q;
   logic [2:0]      cmd_s2_q;
   logic [2:0]      cmd_prev_q;
   logic [2:0]      cmd_edge_q;
   logic [1:0]      lvl_s1_q;
   logic [1:0]      lvl_s2_q;

   logic [1:0]      state_q;
   logic [1:0]      state_d;
   logic [PS_W-1:0] ps_q;
   logic [PS_W-1:0] ps_d;
   logic [3:0]      count_q;
   logic [3:0]      count_d;
   logic            tick_q;
   logic            tick_d;
   logic            tc_q;
   logic            tc_d;
   logic            running_q;
   logic            running_d;

   logic            w_clr;
   logic            w_stp;
   logic            w_sta;
   logic            w_dir_up;
   logic            w_wrap;
   logic            w_ps_last;
   logic            w_step;
   logic            w_at_limit;
   logic            w_release;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_s1_q   <= '0;
         cmd_s2_q   <= '0;
         cmd_prev_q <= '0;
         cmd_edge_q <= '0;
         lvl_s1_q   <= '0;
         lvl_s2_q   <= '0;
      end else begin
         cmd_s1_q   <= {clear, stop, start};
         cmd_s2_q   <= cmd_s1_q;
         cmd_prev_q <= cmd_s2_q;
         cmd_edge_q <= cmd_s2_q & ~cmd_prev_q;
         lvl_s1_q   <= {mode_wrap, dir_up};
         lvl_s2_q   <= lvl_s1_q;
      end
   end

   // Only the highest-priority command present in a cycle is considered.
   assign w_clr      = cmd_edge_q[2];
   assign w_stp      = cmd_edge_q[1] & ~cmd_edge_q[2];
   assign w_sta      = cmd_edge_q[0] & ~cmd_edge_q[1] & ~cmd_edge_q[2];
   assign w_dir_up   = lvl_s2_q[0];
   assign w_wrap     = lvl_s2_q[1];
   assign w_ps_last  = (ps_q == c_PS_LAST);
   assign w_step     = (state_q == c_ST_RUN) & ~w_clr & ~w_stp & w_ps_last;
   assign w_at_limit = w_dir_up ? (count_q == 4'hF) : (count_q == 4'h0);
   assign w_release  = w_dir_up ? (count_q == 4'h0) : (count_q == 4'hF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (w_clr) begin
         state_d = c_ST_IDLE;
      end else begin
         case (state_q)
            c_ST_IDLE: begin
               if (w_sta) state_d = c_ST_RUN;
            end
            c_ST_RUN: begin
               if (w_stp)                            state_d = c_ST_PAUSED;
               else if (w_step && w_at_limit && !w_wrap) state_d = c_ST_DONE;
            end
            c_ST_PAUSED: begin
               if (w_sta) state_d = c_ST_RUN;
            end
            c_ST_DONE: begin
               if (w_sta && w_release) state_d = c_ST_RUN;
            end
            default: state_d = c_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      running_d = (state_d == c_ST_RUN);
      tick_d    = w_step;
      tc_d      = w_step & w_at_limit;
   end

   always_comb begin
      ps_d    = ps_q;
      count_d = count_q;
      if (w_clr) begin
         ps_d    = '0;
         count_d = 4'h0;
      end else if ((state_q == c_ST_IDLE) && w_sta) begin
         ps_d = '0;
      end else if ((state_q == c_ST_RUN) && !w_stp) begin
         ps_d = w_ps_last ? '0 : (ps_q + c_PS_ONE);
         // Modulo-16 arithmetic gives the wrap values directly; saturation just holds.
         if (w_step && !(w_at_limit && !w_wrap)) begin
            count_d = w_dir_up ? (count_q + 4'h1) : (count_q - 4'h1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_q      <= '0;
         count_q   <= 4'h0;
         tick_q    <= 1'b0;
         tc_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         ps_q      <= ps_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         tc_q      <= tc_d;
         running_q <= running_d;
      end
   end

   assign count   = count_q;
   assign tick    = tick_q;
   assign tc      = tc_q;
   assign running = running_q;

endmodule
`default_nettype wire
